pll_lock_detect: RTL and testbench

Lock detector for the digital PLL, directly downstream of the error stage that feeds the loop filter. It watches the signed per-cycle phase/frequency error in the `clk_ref` domain and applies hysteresis to declare and drop lock. It reports lock-loss events and acquisition timeouts as sticky flags, and counts cycle slips for software and bring-up debug.

---
 rtl/pll_lock_detect.sv | 106 ++++++++++
 tb/tb_pll_lock_detect.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_detect.sv
// pll_lock_detect: hysteretic PLL lock detector with sticky loss/timeout flags and a slip counter
module pll_lock_detect #(
  parameter int ERR_SIZE    = 8,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_CNT  = 8,
  parameter int TIMEOUT_CNT = 4096,
  parameter int CNT_SIZE    = 16
) (
  input  logic                       clk_ref,
  input  logic                       n_rst,
  input  logic                       enable,
  input  logic                       err_valid,
  input  logic signed [ERR_SIZE-1:0] error,
  input  logic                       clr_sticky,
  output logic                       locked,
  output logic                       lock_lost,
  output logic                       acq_timeout,
  output logic [1:0]                 lock_state,
  output logic [7:0]                 slip_count
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, HOLD} state_t;
  state_t state, state_n;
  logic [CNT_SIZE-1:0] streak, streak_n, tmo, tmo_n, bad, bad_n;
  logic [ERR_SIZE-1:0] mag;
  logic in_tol, good, fail, set_lost, set_tmo;
  function automatic logic [CNT_SIZE-1:0] sat(input logic [CNT_SIZE-1:0] c);
    return &c ? c : c + CNT_SIZE'(1);
  endfunction
  // the most negative input wraps to 2^(ERR_SIZE-1), which is never within tolerance
  assign mag = error[ERR_SIZE-1] ? $unsigned(-error) : $unsigned(error);
  assign in_tol = mag <= ERR_SIZE'(LOCK_TOL);
  assign good = err_valid & in_tol;
  assign fail = err_valid & ~in_tol;
  assign lock_state = state;
  always_comb begin
    state_n = state;
    streak_n = streak;
    tmo_n = tmo;
    bad_n = bad;
    set_lost = 1'b0;
    set_tmo = 1'b0;
    case (state)
      IDLE: state_n = ACQUIRE;
      ACQUIRE: if (err_valid) begin
        streak_n = in_tol ? sat(streak) : '0;
        tmo_n = sat(tmo);
        if (tmo_n >= CNT_SIZE'(TIMEOUT_CNT)) begin
          set_tmo = 1'b1;
          tmo_n = '0;
        end
        // reaching lock on the same sample as the timeout wins over the timeout
        if (in_tol && streak_n >= CNT_SIZE'(LOCK_CNT)) begin
          state_n = LOCKED;
          streak_n = '0;
          tmo_n = '0;
          set_tmo = 1'b0;
        end
      end
      LOCKED: if (fail) begin
        state_n = HOLD;
        bad_n = CNT_SIZE'(1);
      end
      HOLD: begin
        bad_n = good ? '0 : fail ? sat(bad) : bad;
        state_n = good ? LOCKED : HOLD;
      end
    endcase
    if ((state == LOCKED || state == HOLD) && fail && bad_n >= CNT_SIZE'(UNLOCK_CNT)) begin
      state_n = ACQUIRE;
      set_lost = 1'b1;
      streak_n = '0;
      tmo_n = '0;
      bad_n = '0;
    end
    if (!enable) begin
      state_n = IDLE;
      streak_n = '0;
      tmo_n = '0;
      bad_n = '0;
      set_lost = 1'b0;
      set_tmo = 1'b0;
    end
  end
  always_ff @(posedge clk_ref or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
      streak <= '0;
      tmo <= '0;
      bad <= '0;
      locked <= 1'b0;
      lock_lost <= 1'b0;
      acq_timeout <= 1'b0;
      slip_count <= '0;
    end else begin
      state <= state_n;
      streak <= streak_n;
      tmo <= tmo_n;
      bad <= bad_n;
      locked <= state_n == LOCKED || state_n == HOLD;
      lock_lost <= set_lost | (lock_lost & ~clr_sticky);
      acq_timeout <= set_tmo | (acq_timeout & ~clr_sticky);
      slip_count <= (set_lost && ~&slip_count) ? slip_count + 8'd1 : slip_count;
    end
  end
endmodule

// File: tb/tb_pll_lock_detect.sv
// tb_pll_lock_detect: scenario tasks push expected {locked,lock_lost,acq_timeout,lock_state,slip_count} and compare on pop
module tb_pll_lock_detect;
  logic clk_ref = 1'b0, n_rst = 1'b1, enable = 1'b0, err_valid = 1'b0, clr_sticky = 1'b0;
  logic signed [7:0] error = '0;
  logic locked, lock_lost, acq_timeout;
  logic [1:0] lock_state;
  logic [7:0] slip_count;
  logic [12:0] obs, e_v;
  logic [12:0] sb[$];
  int errors = 0, checks = 0;

  pll_lock_detect dut (
    .clk_ref(clk_ref), .n_rst(n_rst), .enable(enable), .err_valid(err_valid), .error(error),
    .clr_sticky(clr_sticky), .locked(locked), .lock_lost(lock_lost), .acq_timeout(acq_timeout),
    .lock_state(lock_state), .slip_count(slip_count)
  );

  always #5 clk_ref = ~clk_ref;
  assign obs = {locked, lock_lost, acq_timeout, lock_state, slip_count};

  function automatic logic [12:0] pk(input logic l, input logic ll, input logic t, input logic [1:0] s, input logic [7:0] sl);
    return {l, ll, t, s, sl};
  endfunction

  task automatic tick(input logic v, input logic signed [7:0] e, input logic c);
    err_valid = v;
    error = e;
    clr_sticky = c;
    @(posedge clk_ref);
    @(negedge clk_ref);
    err_valid = 1'b0;
    clr_sticky = 1'b0;
  endtask

  task automatic run(input int n, input logic signed [7:0] e);
    repeat (n) tick(1'b1, e, 1'b0);
  endtask

  task automatic test_reset;
    @(negedge clk_ref);
    sb.push_back(pk(0, 0, 0, 2'b00, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL reset: got %h want %h", obs, e_v); end
    n_rst = 1'b0;
  endtask

  task automatic test_basic_lock;
    enable = 1'b1;
    tick(1'b1, 8'sd1, 1'b0);
    sb.push_back(pk(0, 0, 0, 2'b01, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL enable_rise: got %h want %h", obs, e_v); end
    run(63, 8'sd1);
    sb.push_back(pk(0, 0, 0, 2'b01, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL lock_63: got %h want %h", obs, e_v); end
    run(1, 8'sd1);
    sb.push_back(pk(1, 0, 0, 2'b10, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL lock_64: got %h want %h", obs, e_v); end
  endtask

  task automatic test_streak_reset;
    enable = 1'b0;
    tick(1'b1, 8'sd0, 1'b0);
    sb.push_back(pk(0, 0, 0, 2'b00, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL disable_idle: got %h want %h", obs, e_v); end
    enable = 1'b1;
    tick(1'b1, 8'sd0, 1'b0);
    run(63, 8'sd0);
    run(1, 8'sd3);
    run(63, 8'sd0);
    sb.push_back(pk(0, 0, 0, 2'b01, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL streak_63: got %h want %h", obs, e_v); end
    run(1, 8'sd0);
    sb.push_back(pk(1, 0, 0, 2'b10, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL streak_64: got %h want %h", obs, e_v); end
  endtask

  task automatic test_hysteresis;
    run(1, -8'sd5);
    sb.push_back(pk(1, 0, 0, 2'b11, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL hold_enter: got %h want %h", obs, e_v); end
    run(6, -8'sd5);
    sb.push_back(pk(1, 0, 0, 2'b11, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL hold_7: got %h want %h", obs, e_v); end
    run(1, 8'sd0);
    sb.push_back(pk(1, 0, 0, 2'b10, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL hold_recover: got %h want %h", obs, e_v); end
    run(7, -8'sd5);
    sb.push_back(pk(1, 0, 0, 2'b11, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL unlock_7: got %h want %h", obs, e_v); end
    run(1, -8'sd5);
    sb.push_back(pk(0, 1, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL unlock_8: got %h want %h", obs, e_v); end
    tick(1'b0, 8'sd0, 1'b1);
    sb.push_back(pk(0, 0, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL clr_lost: got %h want %h", obs, e_v); end
  endtask

  task automatic test_timeout;
    run(4095, 8'sd50);
    sb.push_back(pk(0, 0, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL tmo_4095: got %h want %h", obs, e_v); end
    run(1, 8'sd50);
    sb.push_back(pk(0, 0, 1, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL tmo_4096: got %h want %h", obs, e_v); end
    tick(1'b0, 8'sd0, 1'b1);
    sb.push_back(pk(0, 0, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL tmo_clr: got %h want %h", obs, e_v); end
    run(4095, 8'sd50);
    tick(1'b1, 8'sd50, 1'b1);
    sb.push_back(pk(0, 0, 1, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL tmo_set_wins: got %h want %h", obs, e_v); end
    tick(1'b0, 8'sd0, 1'b1);
    sb.push_back(pk(0, 0, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL tmo_clr2: got %h want %h", obs, e_v); end
  endtask

  task automatic test_boundary;
    for (int i = 0; i < 63; i++) tick(1'b1, i[0] ? -8'sd2 : 8'sd2, 1'b0);
    run(1, -8'sd128);
    sb.push_back(pk(0, 0, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL min_in_acq: got %h want %h", obs, e_v); end
    for (int i = 0; i < 63; i++) tick(1'b1, i[0] ? 8'sd2 : -8'sd2, 1'b0);
    sb.push_back(pk(0, 0, 0, 2'b01, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL min_resets_streak: got %h want %h", obs, e_v); end
    run(1, 8'sd2);
    sb.push_back(pk(1, 0, 0, 2'b10, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL tol2_lock: got %h want %h", obs, e_v); end
    repeat (1000) tick(1'b0, 8'sd100, 1'b0);
    sb.push_back(pk(1, 0, 0, 2'b10, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL invalid_ignored: got %h want %h", obs, e_v); end
    run(1, -8'sd128);
    sb.push_back(pk(1, 0, 0, 2'b11, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL min_out_locked: got %h want %h", obs, e_v); end
    run(1, -8'sd2);
    sb.push_back(pk(1, 0, 0, 2'b10, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL minus2_in: got %h want %h", obs, e_v); end
    run(1, 8'sd3);
    sb.push_back(pk(1, 0, 0, 2'b11, 1));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL plus3_out: got %h want %h", obs, e_v); end
    run(1, 8'sd0);
  endtask

  task automatic test_slips;
    for (int i = 0; i < 300; i++) begin
      run(8, -8'sd5);
      run(64, 8'sd0);
      if (i == 252) begin
        sb.push_back(pk(1, 1, 0, 2'b10, 8'd254));
        checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL slip_254: got %h want %h", obs, e_v); end
      end
    end
    sb.push_back(pk(1, 1, 0, 2'b10, 8'd255));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL slip_sat: got %h want %h", obs, e_v); end
  endtask

  task automatic test_reset_disable;
    enable = 1'b0;
    tick(1'b1, 8'sd100, 1'b0);
    sb.push_back(pk(0, 1, 0, 2'b00, 8'd255));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL disable_locked: got %h want %h", obs, e_v); end
    enable = 1'b1;
    tick(1'b0, 8'sd0, 1'b0);
    run(64, 8'sd0);
    run(1, -8'sd5);
    sb.push_back(pk(1, 1, 0, 2'b11, 8'd255));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL pre_reset_hold: got %h want %h", obs, e_v); end
    #2 n_rst = 1'b1;
    #1;
    sb.push_back(pk(0, 0, 0, 2'b00, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL async_reset: got %h want %h", obs, e_v); end
    @(negedge clk_ref);
    n_rst = 1'b0;
    tick(1'b1, 8'sd0, 1'b0);
    sb.push_back(pk(0, 0, 0, 2'b01, 0));
    checks++; e_v = sb.pop_front(); if (obs !== e_v) begin errors++; $display("FAIL post_reset_acq: got %h want %h", obs, e_v); end
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_streak_reset();
    test_hysteresis();
    test_timeout();
    test_boundary();
    test_slips();
    test_reset_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
